// File: rtl/uart_tx_scheduler_pkg.sv
// rtl/uart_tx_scheduler_pkg.sv - shared types, constants and index helper for the UART TX scheduler
//
// Purpose : FSM state encoding, grant index width, and a modulo-N index helper
//           used by both the scheduler and its round-robin arbiter.
// Contents: GRANT_W   - width of a requester index (covers up to 8 sources)
//           state_e   - scheduler FSM states
//           wrap_idx  - (base + off) mod n for base, off < n

package uart_tx_scheduler_pkg;

    localparam int GRANT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_WAIT_FALL = 3'd3,
        ST_HOLD      = 3'd4
    } state_e;

    // Both operands are below n, so a single conditional subtract is a full modulo.
    function automatic logic [GRANT_W-1:0] wrap_idx(
        input logic [GRANT_W-1:0] base,
        input logic [GRANT_W-1:0] off,
        input int                 n
    );
        logic [GRANT_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (GRANT_W+1)'(n)) begin
            sum = sum - (GRANT_W+1)'(n);
        end
        return sum[GRANT_W-1:0];
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rtl/uart_tx_scheduler_rr_arbiter.sv - combinational round-robin winner select
//
// Purpose : picks the first requesting index at or after rr_ptr, wrapping mod N_REQ.
// Ports   : req      in  N_REQ    request vector
//           rr_ptr   in  GRANT_W  highest-priority index this round
//           winner   out GRANT_W  selected index (rr_ptr when nothing requests)
//           any_req  out 1        at least one request present

module rr_arbiter
    import uart_tx_scheduler_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic [GRANT_W-1:0] winner,
    output logic               any_req
);

    logic [7:0] req_ext;

    assign req_ext = 8'(req);
    assign any_req = |req;

    // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        winner = rr_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_ext[wrap_idx(rr_ptr, GRANT_W'(k), N_REQ)]) begin
                winner = wrap_idx(rr_ptr, GRANT_W'(k), N_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin sharing of one UART transmitter among N_REQ byte sources
//
// Purpose : grants the transmitter to one source per packet, sequences each byte as
//           wr_en -> tx_busy rise -> tx_busy fall, and releases on last byte, burst
//           limit, or idle timeout.
// Ports   : clk_50m       in  1        system clock
//           rst_n         in  1        asynchronous reset, active-low
//           req_valid     in  N_REQ    source i offers a byte
//           req_data      in  8*N_REQ  byte of source i at [8i+7:8i]
//           req_last      in  N_REQ    offered byte ends the packet
//           req_ready     out N_REQ    one-hot accept, high during ISSUE only
//           uart_din      out 8        byte to transmitter, held until release
//           uart_wr_en    out 1        one-cycle write strobe
//           uart_tx_busy  in  1        transmitter busy
//           grant_active  out 1        a source owns the transmitter
//           grant_id      out 3        owning source index
//           err_lost      out 1        pulse: tx_busy never rose, byte dropped

module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16,
    parameter int HOLD_TMO  = 255,
    parameter int BUSY_TMO  = 8
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           uart_din,
    output logic                 uart_wr_en,
    input  logic                 uart_tx_busy,
    output logic                 grant_active,
    output logic [GRANT_W-1:0]   grant_id,
    output logic                 err_lost
);

    state_e               state_q, state_d;
    logic [GRANT_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GRANT_W-1:0]   grant_id_q, grant_id_d;
    logic [7:0]           burst_cnt_q, burst_cnt_d;
    logic [7:0]           tmo_cnt_q, tmo_cnt_d;
    logic                 last_flag_q, last_flag_d;
    logic [7:0]           din_q, din_d;
    logic                 wr_en_q, wr_en_d;
    logic                 active_q, active_d;
    logic                 err_q, err_d;

    logic [GRANT_W-1:0]   winner;
    logic                 any_req;
    logic                 byte_done;
    logic                 release_grant;

    // Pad per-source signals to 8 entries so a GRANT_W-bit index always selects in range.
    logic [7:0]           data_arr [8];
    logic [7:0]           valid_ext;
    logic [7:0]           last_ext;

    for (genvar g = 0; g < 8; g++) begin : g_unpack
        if (g < N_REQ) begin : g_live
            assign data_arr[g]  = req_data[8*g +: 8];
            assign valid_ext[g] = req_valid[g];
            assign last_ext[g]  = req_last[g];
        end else begin : g_pad
            assign data_arr[g]  = 8'h00;
            assign valid_ext[g] = 1'b0;
            assign last_ext[g]  = 1'b0;
        end
    end

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            last_flag_q <= 1'b0;
            din_q       <= '0;
            wr_en_q     <= 1'b0;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            last_flag_q <= last_flag_d;
            din_q       <= din_d;
            wr_en_q     <= wr_en_d;
            active_q    <= active_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        burst_cnt_d   = burst_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        last_flag_d   = last_flag_q;
        din_d         = din_q;
        err_d         = 1'b0;
        byte_done     = 1'b0;
        release_grant = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A busy transmitter here belongs to someone else; defer arbitration.
                if (any_req && !uart_tx_busy) begin
                    grant_id_d  = winner;
                    burst_cnt_d = '0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                last_flag_d = last_ext[grant_id_q] |
                              ((burst_cnt_q + 8'd1) == 8'(MAX_BURST));
                burst_cnt_d = burst_cnt_q + 8'd1;
                tmo_cnt_d   = '0;
                state_d     = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (uart_tx_busy) begin
                    state_d = ST_WAIT_FALL;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                    // Transmitter never acknowledged: drop the byte and carry on as if it finished.
                    if (tmo_cnt_q == 8'(BUSY_TMO - 1)) begin
                        err_d     = 1'b1;
                        byte_done = 1'b1;
                    end
                end
            end
            ST_WAIT_FALL: begin
                if (!uart_tx_busy) begin
                    byte_done = 1'b1;
                end
            end
            ST_HOLD: begin
                if (valid_ext[grant_id_q] && !uart_tx_busy) begin
                    state_d = ST_ISSUE;
                end else if (tmo_cnt_q == 8'(HOLD_TMO - 1)) begin
                    release_grant = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (byte_done) begin
            if (last_flag_q) begin
                release_grant = 1'b1;
            end else begin
                state_d   = ST_HOLD;
                tmo_cnt_d = '0;
            end
        end

        if (release_grant) begin
            state_d  = ST_IDLE;
            rr_ptr_d = wrap_idx(grant_id_q, GRANT_W'(1), N_REQ);
        end

        // Registered outputs are computed from the next state so they line up with it.
        wr_en_d  = (state_d == ST_ISSUE);
        active_d = (state_d != ST_IDLE);
        if (state_d == ST_ISSUE) begin
            din_d = data_arr[grant_id_d];
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = (state_q == ST_ISSUE) && (grant_id_q == GRANT_W'(i));
        end
    end

    assign uart_din     = din_q;
    assign uart_wr_en   = wr_en_q;
    assign grant_active = active_q;
    assign grant_id     = grant_id_q;
    assign err_lost     = err_q;

endmodule
